// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator side of the data-memory interface for the MEM stage of a
//   5-stage MIPS pipeline. Executes lb/lbu/lh/lhu/lw/sb/sh/sw against a
//   word-wide memory whose read data returns combinationally. Sub-word
//   stores are done as read-modify-write; loads return extended data.
//
//   Optional feature: define MAU_ALIGN_CHECK_EN to fault misaligned
//   half/word accesses (IDLE -> RESP, misalign_err=1, no strobes).
//   Without it, misalign_err is 0 and the low address bits are ignored.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_write         1=store, 0=load
//   req_size          00 byte, 01 half, 1x word
//   req_unsigned      zero-extend loads
//   req_addr/wdata    byte address / store data (low bits for sub-word)
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 after stores), held
//   misalign_err      alignment fault, valid with resp_valid
//   busy              high whenever not IDLE
//   MemRead/MemWrite  memory strobes (memory writes on posedge clk)
//   mem_addr/wdata    word-aligned address / write word
//   mem_rdata         combinational memory read data
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              misalign_err,
   output logic              busy,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WR, S_RMW_RD, S_RMW_WR, S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] merge_q;
   logic [DATA_W-1:0] rdata_q;

   logic              accept;
   logic              misalign_in;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] merged;

   assign accept = req_valid && (state_q == S_IDLE);

`ifdef MAU_ALIGN_CHECK_EN
   logic err_q;
   // Size 11 is treated as a word, so req_size[1] covers both word codes.
   assign misalign_in  = ((req_size == 2'b01) && req_addr[0]) ||
                         (req_size[1] && (req_addr[1:0] != 2'b00));
   assign misalign_err = (state_q == S_RESP) && err_q;
`else
   assign misalign_in  = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Load lane selection and extension (little-endian lanes).
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      ld_byte = mem_rdata[7:0];
      case (addr_q[1:0])
         2'd1:    ld_byte = mem_rdata[15:8];
         2'd2:    ld_byte = mem_rdata[23:16];
         2'd3:    ld_byte = mem_rdata[31:24];
         default: ld_byte = mem_rdata[7:0];
      endcase
      ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (size_q)
         2'b00:   load_ext = {{(DATA_W-8){ld_byte[7] & ~uns_q}}, ld_byte};
         2'b01:   load_ext = {{(DATA_W-16){ld_half[15] & ~uns_q}}, ld_half};
         default: load_ext = mem_rdata;
      endcase
   end

   // Sub-word store merge: replace the target lane of the word read in RMW_RD.
   always_comb begin
      merged = merge_q;
      if (size_q == 2'b00) begin
         case (addr_q[1:0])
            2'd1:    merged[15:8]  = wdata_q[7:0];
            2'd2:    merged[23:16] = wdata_q[7:0];
            2'd3:    merged[31:24] = wdata_q[7:0];
            default: merged[7:0]   = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (misalign_in)      state_d = S_RESP;
               else if (!req_write)  state_d = S_LOAD;
               else if (req_size[1]) state_d = S_WR;
               else                  state_d = S_RMW_RD;
            end
         end
         S_LOAD:   state_d = S_RESP;
         S_WR:     state_d = S_RESP;
         S_RMW_RD: state_d = S_RMW_WR;
         S_RMW_WR: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state so strobes drop the instant reset asserts.
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      resp_valid = (state_q == S_RESP);
      resp_rdata = rdata_q;
      MemRead    = (state_q == S_LOAD) || (state_q == S_RMW_RD);
      MemWrite   = (state_q == S_WR)   || (state_q == S_RMW_WR);
      mem_addr   = '0;
      mem_wdata  = '0;
      if (MemRead || MemWrite) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      if (state_q == S_WR)     mem_wdata = wdata_q;
      if (state_q == S_RMW_WR) mem_wdata = merged;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every register, including the latched request and merge word, is reset so an aborted access leaves nothing behind.
      if (!rst_n) begin
         state_q <= S_IDLE;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         merge_q <= '0;
         rdata_q <= '0;
`ifdef MAU_ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
`ifdef MAU_ALIGN_CHECK_EN
                  err_q   <= misalign_in;
                  if (misalign_in) rdata_q <= '0;
`endif
               end
            end
            S_LOAD:   rdata_q <= load_ext;
            S_RMW_RD: merge_q <= mem_rdata;
            S_WR,
            S_RMW_WR: rdata_q <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a small word memory model
//   (combinational read, write on posedge when MemWrite). Expected values
//   are hand-computed constants.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, misalign_err, busy, MemRead, MemWrite;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:15];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .misalign_err(misalign_err), .busy(busy),
      .MemRead(MemRead), .MemWrite(MemWrite),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[5:2]];
   always @(posedge clk) if (MemWrite) mem[mem_addr[5:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one request and follow it to resp_valid, checking latency (in
   // cycles counted from the accept edge), strobes, address and results.
   task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input int exp_reads, input int exp_writes,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input logic [31:0] exp_wdata);
      int n, t, reads, writes, both, bad_addr;
      logic got;
      logic [31:0] seen_wd, seen_rd;
      logic seen_err;
      n = 0; t = 0; reads = 0; writes = 0; both = 0; bad_addr = 0;
      got = 1'b0; seen_wd = '0; seen_rd = '0; seen_err = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      while (n < 10 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1) req_valid = 1'b0;
         if (MemRead) reads++;
         if (MemWrite) begin
            writes++;
            seen_wd = mem_wdata;
         end
         if (MemRead && MemWrite) both++;
         if ((MemRead || MemWrite) && mem_addr != {addr[31:2], 2'b00}) bad_addr++;
         if (resp_valid) begin
            got = 1'b1;
            seen_rd = resp_rdata;
            seen_err = misalign_err;
         end
      end
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_reads"}, reads, exp_reads);
      check({tag, "_writes"}, writes, exp_writes);
      check({tag, "_both"}, both, 0);
      check({tag, "_addr"}, bad_addr, 0);
      check({tag, "_rdata"}, seen_rd, exp_rdata);
      check({tag, "_err"}, {31'd0, seen_err}, {31'd0, exp_err});
      if (exp_writes > 0) check({tag, "_wdata"}, seen_wd, exp_wdata);
   endtask

   initial begin
      int pulses;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      check("rst_resp", {31'd0, resp_valid}, 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_maddr", mem_addr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_wdata", mem_wdata, 32'd0);

      // Word store then word load.
      run_req("sw8", 1, 2'b10, 0, 32'h8, 32'hAABBCCDD, 2, 0, 1, 32'h0, 0, 32'hAABBCCDD);
      run_req("lw8", 0, 2'b10, 0, 32'h8, 32'h0, 2, 1, 0, 32'hAABBCCDD, 0, 32'h0);
      // Sub-word loads from 0xAABBCCDD.
      run_req("lb9", 0, 2'b00, 0, 32'h9, 32'h0, 2, 1, 0, 32'hFFFFFFCC, 0, 32'h0);
      run_req("lbu9", 0, 2'b00, 1, 32'h9, 32'h0, 2, 1, 0, 32'h000000CC, 0, 32'h0);
      run_req("lhA", 0, 2'b01, 0, 32'hA, 32'h0, 2, 1, 0, 32'hFFFFAABB, 0, 32'h0);
      run_req("lhuA", 0, 2'b01, 1, 32'hA, 32'h0, 2, 1, 0, 32'h0000AABB, 0, 32'h0);
      // Size 11 behaves as a word.
      run_req("lw8_sz3", 0, 2'b11, 0, 32'h8, 32'h0, 2, 1, 0, 32'hAABBCCDD, 0, 32'h0);
      // Read-modify-write stores.
      run_req("shA", 1, 2'b01, 0, 32'hA, 32'h00001234, 3, 1, 1, 32'h0, 0, 32'h1234CCDD);
      run_req("lw8_sh", 0, 2'b10, 0, 32'h8, 32'h0, 2, 1, 0, 32'h1234CCDD, 0, 32'h0);
      run_req("sw8_b", 1, 2'b10, 0, 32'h8, 32'hAABBCCDD, 2, 0, 1, 32'h0, 0, 32'hAABBCCDD);
      run_req("sb8", 1, 2'b00, 0, 32'h8, 32'h00000055, 3, 1, 1, 32'h0, 0, 32'hAABBCC55);
      run_req("lw8_sb", 0, 2'b10, 0, 32'h8, 32'h0, 2, 1, 0, 32'hAABBCC55, 0, 32'h0);
      run_req("sbB", 1, 2'b00, 0, 32'hB, 32'h00000011, 3, 1, 1, 32'h0, 0, 32'h11BBCC55);
      run_req("sw8_c", 1, 2'b10, 0, 32'h8, 32'hAABBCC55, 2, 0, 1, 32'h0, 0, 32'hAABBCC55);

      // Misaligned half.
      run_req("sw4", 1, 2'b10, 0, 32'h4, 32'h87654321, 2, 0, 1, 32'h0, 0, 32'h87654321);
`ifdef MAU_ALIGN_CHECK_EN
      run_req("lh6", 0, 2'b01, 0, 32'h6, 32'h0, 1, 0, 0, 32'h0, 1, 32'h0);
`else
      run_req("lh6", 0, 2'b01, 0, 32'h6, 32'h0, 2, 1, 0, 32'hFFFF8765, 0, 32'h0);
`endif

      // Reset during RMW_RD: memory untouched, no response.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h8; req_wdata = 32'h0;
      check("abort_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_rmwrd", {31'd0, MemRead}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      check("abort_noresp", pulses, 0);
      check("abort_ready2", {31'd0, req_ready}, 32'd1);
      check("abort_mem", mem[2], 32'hAABBCC55);

      // Back-to-back loads with req_valid held high.
      run_req("sw0", 1, 2'b10, 0, 32'h0, 32'h0, 2, 0, 1, 32'h0, 0, 32'h0);
      run_req("sw4_1", 1, 2'b10, 0, 32'h4, 32'h1, 2, 0, 1, 32'h0, 0, 32'h1);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0;
      check("b2b_ready0", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_addr = 32'h4;
      check("b2b_busy1", {31'd0, busy}, 32'd1);
      check("b2b_nready1", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      check("b2b_resp1", {31'd0, resp_valid}, 32'd1);
      check("b2b_data1", resp_rdata, 32'd0);
      check("b2b_busy_resp", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("b2b_gap_busy", {31'd0, busy}, 32'd0);
      check("b2b_gap_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("b2b_busy2", {31'd0, busy}, 32'd1);
      check("b2b_noresp2", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      check("b2b_resp2", {31'd0, resp_valid}, 32'd1);
      check("b2b_data2", resp_rdata, 32'd1);
      @(negedge clk);
      check("b2b_idle", {31'd0, busy}, 32'd0);
      check("b2b_hold", resp_rdata, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data-memory interface for the 5-stage MIPS pipeline. Accepts load/store requests from the MEM stage: lb/lbu/lh/lhu/lw/sb/sh/sw. Drives the word-wide data memory: MemRead/MemWrite, word-aligned address, write data; memory read data returns combinationally.
- Sub-word stores are performed as read-modify-write.
- Loads return extended data.
- busy stalls the pipeline while an access is in flight.

Parameters:
ADDR_W, 32, request/memory address width
DATA_W, 32, data width (fixed word of 4 bytes, little-endian lanes)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept (high only in IDLE)
req_write  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
req_unsigned  input  1  zero-extend loads when 1
req_addr  input  32  byte address
req_wdata  input  32  store data (low bits used for sub-word)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data (0 for stores)
misalign_err  output  1  alignment fault, valid with resp_valid
busy  output  1  high whenever state != IDLE
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable (memory writes on posedge clk)
mem_addr  output  32  {req_addr[31:2],2'b00}
mem_wdata  output  32  word to write
mem_rdata  input  32  combinational memory read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except req_ready=1; latched request and merge register cleared.
- Accept: on a rising edge with req_valid && req_ready, latch all req_* fields. req_valid while busy is ignored; the requester holds it.
- FSM states and paths:
  - IDLE --load--> LOAD --> RESP --> IDLE
  - IDLE --word store--> WR --> RESP --> IDLE
  - IDLE --sub-word store--> RMW_RD --> RMW_WR --> RESP --> IDLE
- State actions:
  - LOAD: MemRead=1. Select lane by addr[1:0] (byte) or addr[1] (half), sign/zero-extend, register into resp_rdata.
  - WR: MemWrite=1; mem_wdata=req_wdata.
  - RMW_RD: MemRead=1; register mem_rdata into merge word.
  - RMW_WR: MemWrite=1; mem_wdata=merge word with the target byte/half lane replaced by req_wdata[7:0]/[15:0].
  - RESP: resp_valid=1 for exactly one cycle; no memory strobes.
- Latency from accept edge to resp_valid high: load 2 cycles, word store 2, sub-word store 3. req_ready rises the cycle after RESP.
- Strobe and address rules:
  - MemRead and MemWrite are never high together; each is high exactly one cycle per access phase.
  - mem_addr is held stable for the whole access.
  - In IDLE/RESP: mem_addr=0, mem_wdata=0.
- resp_rdata holds its value until the next load completes. Stores set resp_rdata=0 at RESP.
- Reset mid-operation: strobes drop immediately. An RMW interrupted before the RMW_WR edge leaves memory unmodified. No resp_valid is produced for the aborted request.

Optional Feature:
Macro MAU_ALIGN_CHECK_EN.
- Defined: half access with addr[0]=1, or word access with addr[1:0]!=0, goes IDLE -> RESP directly. That RESP has misalign_err=1 and resp_rdata=0, with no MemRead/MemWrite.
- Undefined: misalign_err is tied to 0. Ignored low address bits: addr[0] for halves, addr[1:0] for words (access forced aligned).

Test Plan:
- sw addr 0x8 data 0xAABBCCDD, then lw 0x8 -> MemWrite one cycle with mem_addr=0x8; resp_rdata=0xAABBCCDD exactly 2 cycles after accept.
- Memory word 0x8=0xAABBCCDD; lb 0x9 -> 0xFFFFFFCC; lbu 0x9 -> 0x000000CC; lh 0xA -> 0xFFFFAABB; lhu 0xA -> 0x0000AABB.
- sh 0xA data 0x1234 onto 0xAABBCCDD -> MemRead one cycle, then MemWrite one cycle with mem_wdata=0x1234CCDD; resp_valid 3 cycles after accept. Same for sb 0x8 data 0x55 -> 0xAABBCC55.
- lh 0x6 -> with MAU_ALIGN_CHECK_EN: misalign_err=1, resp_rdata=0, no strobes. Without the macro: upper half of word 0x4 returned.
- sb 0x8 data 0x00, rst_n pulsed low during RMW_RD -> word 0x8 unchanged; after release req_ready=1, resp_valid never pulses for it.
- req_valid held high over two lw 0x0 / lw 0x4 (memory 0 / 1) -> second accepted only after first RESP; two resp_valid pulses with data 0 then 1; busy low only between them.
